// File: rtl/wb_gpio_irq_pkg.sv
// Shared definitions for the Wishbone GPIO controller: register indices and byte-lane helper.
package wb_gpio_irq_pkg;

    // Register index = (byte offset from BASE_ADDR) / 4
    typedef enum logic [2:0] {
        RegDir    = 3'd0,
        RegOut    = 3'd1,
        RegIn     = 3'd2,
        RegOutSet = 3'd3,
        RegOutClr = 3'd4,
        RegRiseEn = 3'd5,
        RegFallEn = 3'd6,
        RegStatus = 3'd7
    } reg_e;

    localparam int unsigned RegAddrBits = 5;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{sel[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_gpio_irq_sync_edge.sv
// Input synchroniser chain plus one history flop; yields synchronised pins and edge pulses.
module gpio_sync_edge #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pads,
    output logic [WIDTH-1:0] in_s,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pads;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign in_s = sync_q[STAGES-1];
    assign rise = in_s & ~prev_q;
    assign fall = ~in_s & prev_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO controller: direction/output registers, atomic set/clear and
// per-pin edge interrupts with write-one-to-clear status.
module wb_gpio_irq
    import wb_gpio_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned GPIO_NUM    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [31:0]         wb_addr_i,
    input  logic [31:0]         wb_data_i,
    input  logic [3:0]          wb_sel_i,
    output logic                wb_ack_o,
    output logic                wb_stall_o,
    output logic [31:0]         wb_data_o,
    input  logic [GPIO_NUM-1:0] gpio_i,
    output logic [GPIO_NUM-1:0] gpio_o,
    output logic [GPIO_NUM-1:0] gpio_oe,
    output logic                irq_o
);

    localparam int unsigned N = GPIO_NUM;

    logic [N-1:0] dir_q, dir_d, out_q, out_d;
    logic [N-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [N-1:0] status_q, status_d;
    logic         ack_q;
    logic [31:0]  data_q, data_d;

    logic [N-1:0] in_s, rise, fall, edge_set;
    logic [31:0]  offset, sel_mask, rdata;
    logic [N-1:0] wdata;
    logic         hit, accept, wr;
    reg_e         idx;
    logic         unused_bits;

    gpio_sync_edge #(
        .WIDTH  (N),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .pads   (gpio_i),
        .in_s   (in_s),
        .rise   (rise),
        .fall   (fall)
    );

    assign offset   = wb_addr_i - BASE_ADDR;
    assign hit      = (offset[31:RegAddrBits] == '0);
    assign idx      = reg_e'(offset[4:2]);
    assign accept   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr       = accept & wb_we_i & hit;
    assign sel_mask = lane_mask(wb_sel_i);
    assign wdata    = N'(wb_data_i & sel_mask);

    // Old enables and old DIR gate the edge, so enable changes only affect later edges
    assign edge_set = ((rise & rise_en_q) | (fall & fall_en_q)) & ~dir_q;

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        status_d  = status_q | edge_set;
        if (wr) begin
            case (idx)
                RegDir:    dir_d     = (dir_q & ~N'(sel_mask)) | wdata;
                RegOut:    out_d     = (out_q & ~N'(sel_mask)) | wdata;
                RegOutSet: out_d     = out_q | wdata;
                RegOutClr: out_d     = out_q & ~wdata;
                RegRiseEn: rise_en_d = (rise_en_q & ~N'(sel_mask)) | wdata;
                RegFallEn: fall_en_d = (fall_en_q & ~N'(sel_mask)) | wdata;
                // A new edge in the clearing cycle wins over the clear
                RegStatus: status_d  = (status_q & ~wdata) | edge_set;
                default:   ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (idx)
                RegDir:    rdata = 32'(dir_q);
                RegOut:    rdata = 32'(out_q);
                RegIn:     rdata = 32'(in_s);
                RegRiseEn: rdata = 32'(rise_en_q);
                RegFallEn: rdata = 32'(fall_en_q);
                RegStatus: rdata = 32'(status_q);
                default:   rdata = '0;
            endcase
        end
        data_d = (accept & ~wb_we_i) ? rdata : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            ack_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ack_q     <= accept;
            data_q    <= data_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_data_o   = data_q;
    assign wb_stall_o  = 1'b0;
    assign gpio_o      = out_q;
    assign gpio_oe     = dir_q;
    assign irq_o       = |status_q;
    assign unused_bits = ^{offset[1:0], wb_data_i, sel_mask};

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Randomised bench for wb_gpio_irq: a cycle model of the register map checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_gpio_irq;

    localparam logic [31:0] BASE = 32'h100;
    localparam int N = 8;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
    logic [31:0] wb_addr_i = 0, wb_data_i = 0;
    logic [3:0]  wb_sel_i = 0;
    logic        wb_ack_o, wb_stall_o;
    logic [31:0] wb_data_o;
    logic [N-1:0] gpio_i = 0, gpio_o, gpio_oe;
    logic        irq_o;

    wb_gpio_irq #(
        .BASE_ADDR   (BASE),
        .GPIO_NUM    (N),
        .SYNC_STAGES (S)
    ) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .wb_sel_i   (wb_sel_i),
        .wb_ack_o   (wb_ack_o),
        .wb_stall_o (wb_stall_o),
        .wb_data_o  (wb_data_o),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_oe    (gpio_oe),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: register contents plus the pad values sampled at each of the last S+1 edges
    logic [N-1:0] m_dir, m_out, m_rise, m_fall, m_status;
    logic [N-1:0] hist [S+1];
    logic         m_ack, m_rd;
    logic [31:0]  m_rdata;

    task automatic model_reset();
        m_dir = 0; m_out = 0; m_rise = 0; m_fall = 0; m_status = 0;
        m_ack = 0; m_rd = 0; m_rdata = 0;
        for (int i = 0; i <= S; i++) hist[i] = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Advance one clock; the model consumes the inputs as they stand before the edge
    task automatic step();
        logic [N-1:0] ins, prv, set, d, mask, pad;
        logic [N-1:0] n_dir, n_out, n_rise, n_fall, n_status;
        logic [31:0]  off, n_rdata;
        logic         acc;
        if (!resetn) begin
            @(posedge clk);
            model_reset();
            #1;
            return;
        end
        ins = hist[S-1];
        prv = hist[S];
        set = ((ins & ~prv & m_rise) | (~ins & prv & m_fall)) & ~m_dir;
        n_dir = m_dir; n_out = m_out; n_rise = m_rise; n_fall = m_fall;
        n_status = m_status | set;
        n_rdata = 0;
        acc  = wb_cyc_i && wb_stb_i && !m_ack;
        off  = wb_addr_i - BASE;
        mask = {N{wb_sel_i[0]}};
        d    = wb_data_i[N-1:0] & mask;
        pad  = gpio_i;
        if (acc && off < 32) begin
            if (wb_we_i) begin
                case (off / 4)
                    0: n_dir  = (m_dir & ~mask) | d;
                    1: n_out  = (m_out & ~mask) | d;
                    3: n_out  = m_out | d;
                    4: n_out  = m_out & ~d;
                    5: n_rise = (m_rise & ~mask) | d;
                    6: n_fall = (m_fall & ~mask) | d;
                    7: n_status = (m_status & ~d) | set;
                    default: ;
                endcase
            end else begin
                case (off / 4)
                    0: n_rdata = 32'(m_dir);
                    1: n_rdata = 32'(m_out);
                    2: n_rdata = 32'(ins);
                    5: n_rdata = 32'(m_rise);
                    6: n_rdata = 32'(m_fall);
                    7: n_rdata = 32'(m_status);
                    default: n_rdata = 0;
                endcase
            end
        end
        @(posedge clk);
        m_dir = n_dir; m_out = n_out; m_rise = n_rise; m_fall = n_fall; m_status = n_status;
        m_ack = acc; m_rd = acc && !wb_we_i; m_rdata = n_rdata;
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pad;
        #1;
    endtask

    always @(negedge clk) begin
        check("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        check("gpio_o", 32'(gpio_o), 32'(m_out));
        check("irq_o", 32'(irq_o), 32'(|m_status));
        check("ack", 32'(wb_ack_o), 32'(m_ack));
        check("stall", 32'(wb_stall_o), 0);
        if (m_ack && m_rd) check("rdata", wb_data_o, m_rdata);
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] sel);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
        wb_addr_i = addr; wb_data_i = data; wb_sel_i = sel;
        step();
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        step();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0;
        wb_addr_i = addr; wb_sel_i = 4'hF;
        step();
        check("rd_ack", 32'(wb_ack_o), 1);
        data = wb_data_o;
        wb_cyc_i = 0; wb_stb_i = 0;
        step();
    endtask

    initial begin
        logic [31:0] v;
        int acks;
        resetn = 1'b0;
        model_reset();
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Reset state of every register
        for (int r = 0; r < 8; r++) begin
            bus_read(BASE + 32'(4 * r), v);
            check("reset_reg", v, 0);
        end
        check("reset_oe", 32'(gpio_oe), 0);
        check("reset_irq", 32'(irq_o), 0);

        // Direction, output and atomic set/clear
        bus_write(BASE + 32'h00, 32'h0F, 4'hF);
        bus_write(BASE + 32'h04, 32'hA5, 4'hF);
        check("dir_oe", 32'(gpio_oe), 32'h0F);
        check("out_val", 32'(gpio_o), 32'hA5);
        bus_write(BASE + 32'h0C, 32'h02, 4'hF);
        check("out_set", 32'(gpio_o), 32'hA7);
        bus_write(BASE + 32'h10, 32'h81, 4'hF);
        check("out_clr", 32'(gpio_o), 32'h26);
        bus_write(BASE + 32'h04, 32'hFFFF, 4'b0010);
        bus_read(BASE + 32'h04, v);
        check("out_lane", v, 32'h26);

        // Rising edge on pin 5 with its enable set
        bus_write(BASE + 32'h14, 32'h20, 4'hF);
        gpio_i[5] = 1'b1;
        repeat (S) step();
        check("irq_before", 32'(irq_o), 0);
        step();
        check("irq_after", 32'(irq_o), 1);
        bus_read(BASE + 32'h08, v);
        check("in_pin5", v, 32'h20);
        gpio_i[5] = 1'b0;
        repeat (S + 2) step();
        bus_read(BASE + 32'h1C, v);
        check("fall_ignored", v, 32'h20);

        // W1C, then a clear that collides with a fresh edge
        bus_write(BASE + 32'h1C, 32'h20, 4'hF);
        check("w1c_irq", 32'(irq_o), 0);
        gpio_i[5] = 1'b1;
        repeat (S) step();
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
        wb_addr_i = BASE + 32'h1C; wb_data_i = 32'h20; wb_sel_i = 4'hF;
        step();
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        step();
        check("w1c_collide_irq", 32'(irq_o), 1);
        bus_read(BASE + 32'h1C, v);
        check("w1c_collide", v, 32'h20);
        bus_write(BASE + 32'h1C, 32'hFF, 4'hF);

        // Output pins never raise status
        bus_write(BASE + 32'h00, 32'h08, 4'hF);
        bus_write(BASE + 32'h14, 32'h28, 4'hF);
        gpio_i[3] = 1'b1;
        repeat (S + 2) step();
        gpio_i[3] = 1'b0;
        repeat (S + 2) step();
        bus_read(BASE + 32'h1C, v);
        check("out_pin_no_irq", v, 0);

        // Held strobe: acked every other cycle
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_addr_i = BASE;
        acks = 0;
        repeat (6) begin
            step();
            acks += int'(wb_ack_o);
        end
        wb_cyc_i = 0; wb_stb_i = 0;
        step();
        check("held_acks", 32'(acks), 3);

        // Reset during a write's ack cycle
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
        wb_addr_i = BASE; wb_data_i = 32'hFF; wb_sel_i = 4'hF;
        step();
        check("pre_reset_oe", 32'(gpio_oe), 32'hFF);
        resetn = 1'b0;
        model_reset();
        #1;
        check("reset_ack_drop", 32'(wb_ack_o), 0);
        check("reset_oe_clear", 32'(gpio_oe), 0);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        repeat (2) step();
        resetn = 1'b1;
        step();

        // Random traffic against the model
        repeat (3000) begin
            wb_cyc_i  = ($urandom % 4) != 0;
            wb_stb_i  = ($urandom % 3) != 0;
            wb_we_i   = $urandom % 2;
            wb_addr_i = ($urandom % 16 == 0) ? $urandom : BASE + 32'(4 * $urandom_range(0, 9));
            wb_data_i = $urandom;
            wb_sel_i  = 4'($urandom);
            if ($urandom % 3 == 0) gpio_i = gpio_i ^ N'(1 << ($urandom % N));
            step();
        end
        wb_cyc_i = 0; wb_stb_i = 0;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
